// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the fetch and execute requesters, the shared
// memory port and the arbiter's status outputs.
interface mem_port_arbiter_if;
  logic        f_readReq;
  logic [7:0]  f_addr;
  logic [15:0] f_data;
  logic        f_valueReady;
  logic        e_readReq;
  logic        e_writeReq;
  logic [7:0]  e_addr;
  logic [15:0] e_wdata;
  logic [15:0] e_rdata;
  logic        e_valueReady;
  logic        e_writeDone;
  logic        m_readReq;
  logic        m_writeReq;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        m_ack;
  logic        powerdown;
  logic        busy;
  logic        timeout_err;
  logic        pd_ack;

  modport slave (
    input  f_readReq, f_addr, e_readReq, e_writeReq, e_addr, e_wdata,
    input  m_rdata, m_ack, powerdown,
    output f_data, f_valueReady, e_rdata, e_valueReady, e_writeDone,
    output m_readReq, m_writeReq, m_addr, m_wdata, busy, timeout_err, pd_ack
  );

  modport master (
    output f_readReq, f_addr, e_readReq, e_writeReq, e_addr, e_wdata,
    output m_rdata, m_ack, powerdown,
    input  f_data, f_valueReady, e_rdata, e_valueReady, e_writeDone,
    input  m_readReq, m_writeReq, m_addr, m_wdata, busy, timeout_err, pd_ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory port between fetch reads and execute loads/stores,
// with execute-streak fairness, a BUSY-cycle timeout and a one-way powerdown.
module mem_port_arbiter #(
  parameter int MAX_E_STREAK = 2,
  parameter int TIMEOUT      = 15
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = (MAX_E_STREAK < 1) ? 1 : $clog2(MAX_E_STREAK + 1);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_E_STREAK);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP, S_OFF} state_t;

  state_t      state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        gnt_e_q, gnt_e_d, gnt_wr_q, gnt_wr_d;
  logic        m_read_req_q, m_read_req_d, m_write_req_q, m_write_req_d;
  logic [7:0]  m_addr_q, m_addr_d;
  logic [15:0] m_wdata_q, m_wdata_d, f_data_q, f_data_d, e_rdata_q, e_rdata_d;
  logic        f_value_ready_q, f_value_ready_d, e_value_ready_q, e_value_ready_d;
  logic        e_write_done_q, e_write_done_d, timeout_err_q, timeout_err_d;
  logic        busy_q, busy_d, pd_ack_q, pd_ack_d;
  logic        e_any_s, pick_e_s, pick_wr_s;
  logic [15:0] rsp_data_s;

  // Next-state and next-output computation for the whole arbiter.
  always_comb begin
    state_d         = state_q;
    streak_d        = streak_q;
    cnt_d           = cnt_q;
    gnt_e_d         = gnt_e_q;
    gnt_wr_d        = gnt_wr_q;
    m_read_req_d    = m_read_req_q;
    m_write_req_d   = m_write_req_q;
    m_addr_d        = m_addr_q;
    m_wdata_d       = m_wdata_q;
    f_data_d        = f_data_q;
    e_rdata_d       = e_rdata_q;
    f_value_ready_d = 1'b0;
    e_value_ready_d = 1'b0;
    e_write_done_d  = 1'b0;
    timeout_err_d   = 1'b0;
    busy_d          = busy_q;
    pd_ack_d        = pd_ack_q;
    e_any_s         = bus.e_readReq | bus.e_writeReq;
    pick_e_s        = e_any_s & (~bus.f_readReq | (streak_q != STREAK_MAX));
    pick_wr_s       = pick_e_s & bus.e_writeReq;
    rsp_data_s      = bus.m_ack ? bus.m_rdata : 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (bus.powerdown) begin
          state_d  = S_OFF;
          pd_ack_d = 1'b1;
          busy_d   = 1'b0;
        end else if (bus.f_readReq | e_any_s) begin
          state_d       = S_BUSY;
          busy_d        = 1'b1;
          cnt_d         = {CW{1'b0}};
          gnt_e_d       = pick_e_s;
          gnt_wr_d      = pick_wr_s;
          m_read_req_d  = ~pick_wr_s;
          m_write_req_d = pick_wr_s;
          m_addr_d      = pick_e_s ? bus.e_addr : bus.f_addr;
          m_wdata_d     = pick_wr_s ? bus.e_wdata : 16'h0000;
          // Streak only grows while fetch is actually being held off.
          if (pick_e_s & bus.f_readReq) begin
            streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + SW'(1);
          end else begin
            streak_d = {SW{1'b0}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (bus.m_ack | (cnt_q == CNT_LAST)) begin
          state_d       = S_RESP;
          m_read_req_d  = 1'b0;
          m_write_req_d = 1'b0;
          timeout_err_d = ~bus.m_ack;
          if (gnt_wr_q) begin
            e_write_done_d = 1'b1;
          end else if (gnt_e_q) begin
            e_value_ready_d = 1'b1;
            e_rdata_d       = rsp_data_s;
          end else begin
            f_value_ready_d = 1'b1;
            f_data_d        = rsp_data_s;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        busy_d = 1'b0;
        if (bus.powerdown) begin
          state_d  = S_OFF;
          pd_ack_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OFF: begin
        state_d  = S_OFF;
        pd_ack_d = 1'b1;
        busy_d   = 1'b0;
      end
      default: begin
        state_d       = S_IDLE;
        m_read_req_d  = 1'b0;
        m_write_req_d = 1'b0;
        busy_d        = 1'b0;
        pd_ack_d      = 1'b0;
      end
    endcase
  end

  // State and registered-output flops; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      streak_q        <= {SW{1'b0}};
      cnt_q           <= {CW{1'b0}};
      gnt_e_q         <= 1'b0;
      gnt_wr_q        <= 1'b0;
      m_read_req_q    <= 1'b0;
      m_write_req_q   <= 1'b0;
      m_addr_q        <= 8'h00;
      m_wdata_q       <= 16'h0000;
      f_data_q        <= 16'h0000;
      e_rdata_q       <= 16'h0000;
      f_value_ready_q <= 1'b0;
      e_value_ready_q <= 1'b0;
      e_write_done_q  <= 1'b0;
      timeout_err_q   <= 1'b0;
      busy_q          <= 1'b0;
      pd_ack_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      streak_q        <= streak_d;
      cnt_q           <= cnt_d;
      gnt_e_q         <= gnt_e_d;
      gnt_wr_q        <= gnt_wr_d;
      m_read_req_q    <= m_read_req_d;
      m_write_req_q   <= m_write_req_d;
      m_addr_q        <= m_addr_d;
      m_wdata_q       <= m_wdata_d;
      f_data_q        <= f_data_d;
      e_rdata_q       <= e_rdata_d;
      f_value_ready_q <= f_value_ready_d;
      e_value_ready_q <= e_value_ready_d;
      e_write_done_q  <= e_write_done_d;
      timeout_err_q   <= timeout_err_d;
      busy_q          <= busy_d;
      pd_ack_q        <= pd_ack_d;
    end
  end

  assign bus.m_readReq    = m_read_req_q;
  assign bus.m_writeReq   = m_write_req_q;
  assign bus.m_addr       = m_addr_q;
  assign bus.m_wdata      = m_wdata_q;
  assign bus.f_data       = f_data_q;
  assign bus.e_rdata      = e_rdata_q;
  assign bus.f_valueReady = f_value_ready_q;
  assign bus.e_valueReady = e_value_ready_q;
  assign bus.e_writeDone  = e_write_done_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.busy         = busy_q;
  assign bus.pd_ack       = pd_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven single transactions
// through a scoreboard, plus hand-written streak, reset and powerdown sequences.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if bus_if ();

  mem_port_arbiter #(.MAX_E_STREAK(2), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          f_rd;
    bit          e_rd;
    bit          e_wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          ack_dly;
    bit          exp_wr;
    int          exp_kind;
    logic [15:0] exp_data;
    bit          exp_tmo;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int          kind;
    logic [15:0] f_data;
    logic [15:0] e_rdata;
    bit          tmo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  logic [15:0] model_f = 16'h0000;
  logic [15:0] model_e = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drop_reqs();
    bus_if.f_readReq  = 1'b0;
    bus_if.e_readReq  = 1'b0;
    bus_if.e_writeReq = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t got;
    int   n;
    bit   done;
    logic [7:0] other;
    other             = ~v.addr;
    bus_if.f_readReq  = v.f_rd;
    bus_if.e_readReq  = v.e_rd;
    bus_if.e_writeReq = v.e_wr;
    bus_if.f_addr     = v.f_rd ? v.addr : other;
    bus_if.e_addr     = v.f_rd ? other : v.addr;
    bus_if.e_wdata    = v.wdata;
    bus_if.m_rdata    = v.rdata;
    @(posedge clk); #1;
    check({v.name, " strobes"}, {bus_if.m_readReq, bus_if.m_writeReq}, {!v.exp_wr, v.exp_wr});
    check({v.name, " m_addr"}, bus_if.m_addr, v.addr);
    check({v.name, " busy"}, bus_if.busy, 1'b1);
    if (v.exp_wr) check({v.name, " m_wdata"}, bus_if.m_wdata, v.wdata);
    if (v.exp_kind == 0) model_f = v.exp_data;
    if (v.exp_kind == 1) model_e = v.exp_data;
    e = '{kind: v.exp_kind, f_data: model_f, e_rdata: model_e, tmo: v.exp_tmo, lat: v.exp_lat};
    sb.push_back(e);
    n = 0;
    done = 1'b0;
    bus_if.m_ack = (v.ack_dly == 0);
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus_if.f_valueReady | bus_if.e_valueReady | bus_if.e_writeDone) begin
        done = 1'b1;
        bus_if.m_ack = 1'b0;
        drop_reqs();
        if (sb.size() == 0) begin
          check({v.name, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
          got = sb.pop_front();
          check({v.name, " pulses"}, {bus_if.f_valueReady, bus_if.e_valueReady, bus_if.e_writeDone},
                {got.kind == 0, got.kind == 1, got.kind == 2});
          check({v.name, " timeout_err"}, bus_if.timeout_err, got.tmo);
          check({v.name, " latency"}, n, got.lat);
          check({v.name, " f_data"}, bus_if.f_data, got.f_data);
          check({v.name, " e_rdata"}, bus_if.e_rdata, got.e_rdata);
          check({v.name, " strobes low"}, {bus_if.m_readReq, bus_if.m_writeReq}, 2'b00);
        end
      end else begin
        check({v.name, " held"}, {bus_if.m_readReq, bus_if.m_writeReq, bus_if.m_addr},
              {!v.exp_wr, v.exp_wr, v.addr});
        bus_if.m_ack = (n == v.ack_dly);
      end
    end
    if (!done) begin
      check({v.name, " completion within bound"}, 32'd0, 32'd1);
      drop_reqs();
      bus_if.m_ack = 1'b0;
      sb.delete();
    end
    @(posedge clk); #1;
    check({v.name, " back to idle"}, {bus_if.busy, bus_if.f_valueReady, bus_if.e_valueReady,
          bus_if.e_writeDone, bus_if.timeout_err}, 5'b00000);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_f = 16'h0000;
    model_e = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  exp_e;
    drop_reqs();
    bus_if.f_addr    = 8'h00;
    bus_if.e_addr    = 8'h00;
    bus_if.e_wdata   = 16'h0000;
    bus_if.m_rdata   = 16'h0000;
    bus_if.m_ack     = 1'b0;
    bus_if.powerdown = 1'b0;

    // name, f, er, ew, addr, wdata, rdata, ack_dly, exp_wr, kind, data, tmo, lat
    vecs[0] = '{"f_read",      1, 0, 0, 8'h10, 16'h0000, 16'h1234,  0, 0, 0, 16'h1234, 0, 1};
    vecs[1] = '{"e_write",     0, 0, 1, 8'h2D, 16'h0315, 16'hDEAD,  0, 1, 2, 16'h0000, 0, 1};
    vecs[2] = '{"e_load_tmo",  0, 1, 0, 8'h1A, 16'h0000, 16'hFFFF, -1, 0, 1, 16'h0000, 1, 15};
    vecs[3] = '{"e_rd_wr",     0, 1, 1, 8'h33, 16'hBEEF, 16'h5555,  1, 1, 2, 16'h0000, 0, 2};
    vecs[4] = '{"e_load_dly3", 0, 1, 0, 8'h44, 16'h0000, 16'hA5A5,  3, 0, 1, 16'hA5A5, 0, 4};
    vecs[5] = '{"f_ack_last",  1, 0, 0, 8'hFF, 16'h0000, 16'h0001, 14, 0, 0, 16'h0001, 0, 15};
    vecs[6] = '{"f_read_tmo",  1, 0, 0, 8'h00, 16'h0000, 16'h7E7E, -1, 0, 0, 16'h0000, 1, 15};
    vecs[7] = '{"e_load",      0, 1, 0, 8'h80, 16'h0000, 16'hC001,  0, 0, 1, 16'hC001, 0, 1};

    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {bus_if.m_readReq, bus_if.m_writeReq, bus_if.busy, bus_if.pd_ack,
          bus_if.f_valueReady, bus_if.e_valueReady, bus_if.e_writeDone, bus_if.timeout_err}, 8'h00);
    check("reset data", {bus_if.f_data, bus_if.e_rdata}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Both requesters held: execute gets two grants, then fetch one.
    bus_if.f_readReq  = 1'b1;
    bus_if.e_writeReq = 1'b1;
    bus_if.f_addr     = 8'h10;
    bus_if.e_addr     = 8'h2D;
    bus_if.e_wdata    = 16'h0315;
    bus_if.m_rdata    = 16'h0F0F;
    for (int g = 0; g < 6; g++) begin
      exp_e = (g % 3) != 2;
      n = 0;
      while (!(bus_if.m_readReq | bus_if.m_writeReq) && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      check($sformatf("streak grant %0d", g), {bus_if.m_writeReq, bus_if.m_readReq}, {exp_e, !exp_e});
      check($sformatf("streak addr %0d", g), bus_if.m_addr, exp_e ? 8'h2D : 8'h10);
      if (exp_e) check($sformatf("streak wdata %0d", g), bus_if.m_wdata, 16'h0315);
      bus_if.m_ack = 1'b1;
      @(posedge clk); #1;
      bus_if.m_ack = 1'b0;
      check($sformatf("streak done %0d", g), {bus_if.e_writeDone, bus_if.f_valueReady}, {exp_e, !exp_e});
      if (!exp_e) check($sformatf("streak f_data %0d", g), bus_if.f_data, 16'h0F0F);
    end
    drop_reqs();
    repeat (2) @(posedge clk);
    #1;
    model_f = 16'h0F0F;

    // Reset in the middle of a fetch read.
    bus_if.f_readReq = 1'b1;
    bus_if.f_addr    = 8'h55;
    @(posedge clk); #1;
    check("rst mid busy strobe", bus_if.m_readReq, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rst async strobes", {bus_if.m_readReq, bus_if.m_writeReq, bus_if.busy}, 3'b000);
    check("rst async data", {bus_if.f_data, bus_if.e_rdata}, 32'h0);
    bus_if.f_readReq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_f = 16'h0000;
    model_e = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst no pulse", {bus_if.f_valueReady, bus_if.e_valueReady, bus_if.e_writeDone,
            bus_if.m_readReq, bus_if.busy}, 5'b00000);
    end
    run_vec(vecs[0]);

    // Powerdown arriving during a load lets the load finish, then parks in OFF.
    bus_if.e_readReq = 1'b1;
    bus_if.e_addr    = 8'h1A;
    bus_if.m_rdata   = 16'h7777;
    @(posedge clk); #1;
    bus_if.powerdown = 1'b1;
    @(posedge clk); #1;
    check("pd busy held", {bus_if.m_readReq, bus_if.busy, bus_if.pd_ack}, 3'b110);
    bus_if.m_ack = 1'b1;
    @(posedge clk); #1;
    bus_if.m_ack = 1'b0;
    check("pd load done", {bus_if.e_valueReady, bus_if.pd_ack}, 2'b10);
    check("pd load data", bus_if.e_rdata, 16'h7777);
    bus_if.e_readReq = 1'b0;
    @(posedge clk); #1;
    check("pd off", {bus_if.pd_ack, bus_if.busy, bus_if.e_valueReady}, 3'b100);
    bus_if.powerdown = 1'b0;
    bus_if.f_readReq = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("pd ignores req", {bus_if.m_readReq, bus_if.pd_ack}, 2'b01);
    end
    bus_if.f_readReq = 1'b0;

    // Powerdown wins over a simultaneous request in IDLE.
    do_reset();
    check("reset clears pd_ack", bus_if.pd_ack, 1'b0);
    bus_if.powerdown = 1'b1;
    bus_if.f_readReq = 1'b1;
    @(posedge clk); #1;
    check("pd priority", {bus_if.pd_ack, bus_if.m_readReq, bus_if.busy}, 3'b100);
    drop_reqs();
    bus_if.powerdown = 1'b0;
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_E_STREAK, default 2, max consecutive execute grants while fetch waits.
REQ-002 Parameter TIMEOUT, default 15, BUSY cycles without m_ack before abort.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 f_readReq  in  1  fetch read request, level, held until f_valueReady.
REQ-006 f_addr  in  8  fetch address.
REQ-007 f_data  out  16  fetch read data, valid while f_valueReady high.
REQ-008 f_valueReady  out  1  one-cycle fetch completion pulse.
REQ-009 e_readReq  in  1  execute load request, level, held until e_valueReady.
REQ-010 e_writeReq  in  1  execute store request, level, held until e_writeDone.
REQ-011 e_addr  in  8  execute load/store address.
REQ-012 e_wdata  in  16  execute store data.
REQ-013 e_rdata  out  16  execute load data, valid while e_valueReady high.
REQ-014 e_valueReady  out  1  one-cycle load completion pulse.
REQ-015 e_writeDone  out  1  one-cycle store completion pulse.
REQ-016 m_readReq / m_writeReq  out  1 each  memory read/write strobes.
REQ-017 m_addr  out  8; m_wdata  out  16  memory address and write data.
REQ-018 m_rdata  in  16; m_ack  in  1  memory read data and completion.
REQ-019 powerdown  in  1  request to quiesce the port.
REQ-020 busy  out  1  high in BUSY and RESP.
REQ-021 timeout_err  out  1  one-cycle pulse, coincident with the aborted completion pulse.
REQ-022 pd_ack  out  1  high in OFF.

Function
REQ-023 FSM states IDLE, BUSY, RESP, OFF; registered outputs only.
REQ-024 IDLE: at posedge, powerdown=1 -> OFF (takes priority over requests); else any request -> BUSY with grant latched; else stay.
REQ-025 Grant rule: only F -> F; only E -> E; both -> E unless e_streak==MAX_E_STREAK, then F.
REQ-026 e_streak: +1 on E grant while f_readReq high; cleared on F grant or on E grant with f_readReq low; saturates at MAX_E_STREAK.
REQ-027 e_readReq and e_writeReq both high: write served, read ignored for that grant.
REQ-028 BUSY: m_addr/m_wdata/m_readReq/m_writeReq driven from latched grant, held constant all of BUSY; new requests, address changes and powerdown ignored.
REQ-029 BUSY: m_ack=1 at posedge -> RESP, m_rdata captured into f_data or e_rdata (reads only); strobes low from RESP.
REQ-030 BUSY cycle counter cleared on entry; count reaching TIMEOUT with m_ack low -> RESP, data register loaded 16'h0000, timeout_err pulsed.
REQ-031 RESP: exactly one of f_valueReady/e_valueReady/e_writeDone high one cycle; no grant; next state IDLE (OFF if powerdown=1).
REQ-032 Minimum latency: request sampled at edge N, strobe high after N, m_ack sampled at N+1, done pulse in cycle after N+1 (2 cycles).
REQ-033 Requester drops its request by the edge ending RESP; a request still high in IDLE is a new request.
REQ-034 OFF: all strobes and pulses low, requests ignored, pd_ack=1; exit only by reset.
REQ-035 f_data/e_rdata hold last value outside their pulse.

Reset
REQ-036 rst=0 forces immediately, any state: IDLE, all outputs 0, f_data=e_rdata=0, e_streak=0, cycle counter=0.
REQ-037 Reset mid-BUSY aborts transaction: no completion pulse, strobes drop asynchronously.

Verification
REQ-038 f_readReq, f_addr=8'h10, m_ack one cycle later with m_rdata=16'h1234 -> m_readReq one cycle, f_valueReady pulse with f_data=16'h1234, 2-cycle latency.
REQ-039 f_readReq and e_writeReq (e_addr=8'h2D, e_wdata=16'h0315) held together, ack each after 1 cycle -> grants E,E,F,E,E,F... with MAX_E_STREAK=2; m_wdata=16'h0315 on E writes.
REQ-040 e_readReq, e_addr=8'h1A, m_ack never -> after 15 BUSY cycles e_valueReady and timeout_err pulse together, e_rdata=16'h0000.
REQ-041 powerdown=1 during BUSY of a load -> load completes with e_valueReady, then OFF, pd_ack=1, later f_readReq produces no m_readReq.
REQ-042 rst low mid-BUSY -> strobes 0 immediately, no done pulse, state IDLE after release; subsequent request served normally.
REQ-043 e_readReq and e_writeReq together -> m_writeReq only, e_writeDone pulse, e_valueReady stays 0.
